// File: rtl/poly_fan.sv
// Fan triangulator: accepts one convex polygon per handshake and streams it
// out as triangles (v0, vi, vi+1); polygons with fewer than 3 vertices are dropped.
module poly_fan #(
  parameter int MAX_VERTS = 8,
  parameter int COORD_W   = 16,
  parameter int CNT_W     = 4
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CNT_W-1:0]             in_count,
  input  logic [MAX_VERTS*COORD_W-1:0] in_x,
  input  logic [MAX_VERTS*COORD_W-1:0] in_y,
  output logic                         tri_valid,
  input  logic                         tri_ready,
  output logic [COORD_W-1:0]           tri_x0,
  output logic [COORD_W-1:0]           tri_y0,
  output logic [COORD_W-1:0]           tri_x1,
  output logic [COORD_W-1:0]           tri_y1,
  output logic [COORD_W-1:0]           tri_x2,
  output logic [COORD_W-1:0]           tri_y2,
  output logic                         tri_last,
  output logic                         degen
);

  localparam int VW = MAX_VERTS * COORD_W;
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_VERTS);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] n_eff, n_lat, idx, idx_nx;
  logic [VW-1:0]    lat_x, lat_y;
  logic             in_fire, tri_fire, poly_ok, last_fire;
  int               sel1, sel2;

  assign n_eff     = (in_count > MAX_N) ? MAX_N : in_count;
  assign poly_ok   = (n_eff >= CNT_W'(3));
  assign in_ready  = (state == IDLE) && !n_rst;
  assign in_fire   = in_valid && in_ready;
  assign tri_fire  = tri_valid && tri_ready;
  // idx is compared against the latched count, so it never needs to wrap
  assign last_fire = tri_fire && (idx == n_lat - CNT_W'(2));
  assign idx_nx    = idx + CNT_W'(1);
  assign sel1      = int'(idx_nx);
  assign sel2      = sel1 + 1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_fire && poly_ok) state_nx = EMIT;
      EMIT: if (last_fire)          state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  // NOTE: vertex storage is deliberately not reset; it is only read in EMIT,
  // which can only be entered through a fresh load.
  always_ff @(posedge clk) begin
    if (in_fire && poly_ok) begin
      lat_x <= in_x;
      lat_y <= in_y;
      n_lat <= n_eff;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      idx       <= '0;
      tri_valid <= 1'b0;
      tri_last  <= 1'b0;
      degen     <= 1'b0;
      tri_x0    <= '0;
      tri_y0    <= '0;
      tri_x1    <= '0;
      tri_y1    <= '0;
      tri_x2    <= '0;
      tri_y2    <= '0;
    end else begin
      degen <= in_fire && !poly_ok;
      if (in_fire && poly_ok) begin
        idx       <= CNT_W'(1);
        tri_valid <= 1'b1;
        tri_last  <= (n_eff == CNT_W'(3));
        tri_x0    <= in_x[0 +: COORD_W];
        tri_y0    <= in_y[0 +: COORD_W];
        tri_x1    <= in_x[COORD_W +: COORD_W];
        tri_y1    <= in_y[COORD_W +: COORD_W];
        tri_x2    <= in_x[2*COORD_W +: COORD_W];
        tri_y2    <= in_y[2*COORD_W +: COORD_W];
      end else if (last_fire) begin
        tri_valid <= 1'b0;
        tri_last  <= 1'b0;
      end else if (tri_fire) begin
        // v0 stays in place; only the trailing edge of the fan advances
        idx      <= idx_nx;
        tri_last <= (idx_nx == n_lat - CNT_W'(2));
        tri_x1   <= lat_x[sel1*COORD_W +: COORD_W];
        tri_y1   <= lat_y[sel1*COORD_W +: COORD_W];
        tri_x2   <= lat_x[sel2*COORD_W +: COORD_W];
        tri_y2   <= lat_y[sel2*COORD_W +: COORD_W];
      end
    end
  end

endmodule
